// File: rtl/pulse_counter_mc.sv
// Multi-channel gated pulse counter: counts selected edges on each channel during a
// gate_len-clock window, then snapshots all counters. Optional input synchroniser: PULSE_CNT_SYNC_EN.
module pulse_counter_mc #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int GATE_W      = 16,
    parameter int SATURATE    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       in_pulse,
    input  logic [CHANNELS-1:0]       ch_enable,
    input  logic [1:0]                edge_sel,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      clear,
    input  logic [GATE_W-1:0]         gate_len,
    output logic                      busy,
    output logic                      done,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS*WIDTH-1:0] capture,
    output logic [CHANNELS-1:0]       overflow
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t              state;
    state_t              state_next;
    logic [GATE_W-1:0]   timer;
    logic [CHANNELS-1:0] sampled;
    logic [CHANNELS-1:0] prev;
    logic [CHANNELS-1:0] edge_hit;
    logic                start_ok;

    if (CHANNELS < 1 || CHANNELS > 16 || WIDTH < 4 || WIDTH > 32 || SYNC_STAGES < 2) begin : g_param_check
        $error("pulse_counter_mc: parameter out of range");
    end

`ifdef PULSE_CNT_SYNC_EN
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], in_pulse};
    end

    assign sampled = sync_q[SYNC_STAGES-1];
`else
    assign sampled = in_pulse;
`endif

    // History runs in every state so the first counted edge is judged against real input history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= '0;
        else     prev <= sampled;
    end

    always_comb begin
        edge_hit = '0;
        case (edge_sel)
            2'b00:   edge_hit = sampled & ~prev;
            2'b01:   edge_hit = ~sampled & prev;
            2'b10:   edge_hit = sampled ^ prev;
            default: edge_hit = '0;
        endcase
    end

    assign start_ok = (state == IDLE) && start && (gate_len != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = COUNT;
            COUNT: begin
                if (abort)                     state_next = IDLE;
                else if (timer == GATE_W'(1)) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  timer <= '0;
        else if (start_ok)        timer <= gate_len;
        else if (state == COUNT)  timer <= timer - GATE_W'(1);
    end

    assign busy = (state == COUNT);
    assign done = (state == DONE);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             inc;
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cap_q;
        logic             ovf_q;

        assign inc = (state == COUNT) && ch_enable[i] && edge_hit[i];

        // clear and window start both win over a same-cycle increment
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
                cap_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (clear || start_ok) begin
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
                end else if (inc) begin
                    if (cnt_q == CNT_MAX) begin
                        ovf_q <= 1'b1;
                        cnt_q <= (SATURATE != 0) ? CNT_MAX : '0;
                    end else begin
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                end
                if (state == DONE) cap_q <= cnt_q;
            end
        end

        assign count[i*WIDTH +: WIDTH]   = cnt_q;
        assign capture[i*WIDTH +: WIDTH] = cap_q;
        assign overflow[i]               = ovf_q;
    end

endmodule

// File: tb/tb_pulse_counter_mc.sv
// Self-checking bench for pulse_counter_mc: three instances (16-bit wrap, 4-bit wrap,
// 4-bit saturate) share stimulus and are compared against a window-level reference model.
`timescale 1ns/1ps
module tb_pulse_counter_mc;

`ifdef PULSE_CNT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_pulse;
    logic [3:0]  ch_enable;
    logic [1:0]  edge_sel;
    logic        start;
    logic        abort;
    logic        clear;
    logic [15:0] gate_len;

    logic        busy, done;
    logic [63:0] count, capture;
    logic [3:0]  overflow;
    logic        busy_w, done_w, busy_s, done_s;
    logic [15:0] count_w, capture_w, count_s, capture_s;
    logic [3:0]  overflow_w, overflow_s;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: remaining window cycles, pending done, per-config counters
    int         m_left;
    bit         m_done;
    int         m_cnt [3][4];
    bit         m_ov  [3][4];
    int         m_cap [3][4];
    logic [3:0] m_prev;
    logic [3:0] m_dly [2];

    pulse_counter_mc #(.CHANNELS(4), .WIDTH(16), .GATE_W(16), .SATURATE(0), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_pulse(in_pulse), .ch_enable(ch_enable), .edge_sel(edge_sel),
        .start(start), .abort(abort), .clear(clear), .gate_len(gate_len),
        .busy(busy), .done(done), .count(count), .capture(capture), .overflow(overflow));

    pulse_counter_mc #(.CHANNELS(4), .WIDTH(4), .GATE_W(16), .SATURATE(0), .SYNC_STAGES(2)) dut_w (
        .clk(clk), .rst(rst), .in_pulse(in_pulse), .ch_enable(ch_enable), .edge_sel(edge_sel),
        .start(start), .abort(abort), .clear(clear), .gate_len(gate_len),
        .busy(busy_w), .done(done_w), .count(count_w), .capture(capture_w), .overflow(overflow_w));

    pulse_counter_mc #(.CHANNELS(4), .WIDTH(4), .GATE_W(16), .SATURATE(1), .SYNC_STAGES(2)) dut_s (
        .clk(clk), .rst(rst), .in_pulse(in_pulse), .ch_enable(ch_enable), .edge_sel(edge_sel),
        .start(start), .abort(abort), .clear(clear), .gate_len(gate_len),
        .busy(busy_s), .done(done_s), .count(count_s), .capture(capture_s), .overflow(overflow_s));

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_left = 0;
        m_done = 1'b0;
        m_prev = '0;
        m_dly[0] = '0;
        m_dly[1] = '0;
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < 4; c++) begin
                m_cnt[d][c] = 0;
                m_ov[d][c]  = 1'b0;
                m_cap[d][c] = 0;
            end
    endfunction

    function automatic void model_step();
        logic [3:0] s, e;
        bit counting, was_done, accept;
        int maxv;
`ifdef PULSE_CNT_SYNC_EN
        s = m_dly[1];
        m_dly[1] = m_dly[0];
        m_dly[0] = in_pulse;
`else
        s = in_pulse;
`endif
        case (edge_sel)
            2'b00:   e = s & ~m_prev;
            2'b01:   e = ~s & m_prev;
            2'b10:   e = s ^ m_prev;
            default: e = '0;
        endcase
        counting = (m_left > 0);
        was_done = m_done;
        accept   = !counting && !was_done && start && (gate_len != 0);
        for (int d = 0; d < 3; d++) begin
            maxv = (d == 0) ? 65535 : 15;
            for (int c = 0; c < 4; c++) begin
                if (was_done) m_cap[d][c] = m_cnt[d][c];
                if (clear || accept) begin
                    m_cnt[d][c] = 0;
                    m_ov[d][c]  = 1'b0;
                end else if (counting && ch_enable[c] && e[c]) begin
                    if (m_cnt[d][c] == maxv) begin
                        m_ov[d][c] = 1'b1;
                        if (d != 2) m_cnt[d][c] = 0;
                    end else begin
                        m_cnt[d][c] = m_cnt[d][c] + 1;
                    end
                end
            end
        end
        m_done = 1'b0;
        if (accept) m_left = gate_len;
        else if (counting) begin
            if (abort)            m_left = 0;
            else if (m_left == 1) begin m_left = 0; m_done = 1'b1; end
            else                  m_left = m_left - 1;
        end
        m_prev = s;
    endfunction

    function automatic logic [63:0] exp_count(int d);
        logic [63:0] v = '0;
        for (int c = 0; c < 4; c++)
            if (d == 0) v[c*16 +: 16] = 16'(m_cnt[d][c]);
            else        v[c*4 +: 4]   = 4'(m_cnt[d][c]);
        return v;
    endfunction

    function automatic logic [63:0] exp_capture(int d);
        logic [63:0] v = '0;
        for (int c = 0; c < 4; c++)
            if (d == 0) v[c*16 +: 16] = 16'(m_cap[d][c]);
            else        v[c*4 +: 4]   = 4'(m_cap[d][c]);
        return v;
    endfunction

    function automatic logic [3:0] exp_ov(int d);
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = m_ov[d][c];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_pulse  = '0;
        ch_enable = 4'hf;
        edge_sel  = 2'b00;
        start     = 1'b0;
        abort     = 1'b0;
        clear     = 1'b0;
        gate_len  = 16'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        n_total++; if (busy !== 1'b0)      $display("[TB] FAIL reset_busy: got %0h want 0", busy);         else n_pass++;
        n_total++; if (done !== 1'b0)      $display("[TB] FAIL reset_done: got %0h want 0", done);         else n_pass++;
        n_total++; if (count !== 64'd0)    $display("[TB] FAIL reset_count: got %0h want 0", count);       else n_pass++;
        n_total++; if (capture !== 64'd0)  $display("[TB] FAIL reset_capture: got %0h want 0", capture);   else n_pass++;
        n_total++; if (overflow !== 4'd0)  $display("[TB] FAIL reset_overflow: got %0h want 0", overflow); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rising();
        int s0[10];
        int s2[3];
        int done_at = -1;
        int busy_cycles = 0;
        logic [3:0] p;
        for (int k = 0; k < 10; k++) s0[k] = 3 + 9*k + $urandom_range(0, 2);
        for (int k = 0; k < 3; k++)  s2[k] = 20 + 25*k + $urandom_range(0, 5);
        idle_inputs();
        gate_len = 16'd100;
        for (int j = 0; j <= 101; j++) begin
            p = '0;
            for (int k = 0; k < 10; k++) if (j == s0[k] || j == s0[k] + 1) p[0] = 1'b1;
            for (int k = 0; k < 3; k++)  if (j >= s2[k] && j < s2[k] + 3)  p[2] = 1'b1;
            in_pulse = p;
            start    = (j == 0);
            tick();
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1 && done_at < 0) done_at = j + 1;
            n_total++;
            if (count !== exp_count(0)) $display("[TB] FAIL rise_count j=%0d: got %0h want %0h", j, count, exp_count(0));
            else n_pass++;
        end
        in_pulse = '0;
        n_total++; if (done_at != 101)      $display("[TB] FAIL rise_done_cycle: got %0d want 101", done_at);  else n_pass++;
        n_total++; if (busy_cycles != 100)  $display("[TB] FAIL rise_busy_len: got %0d want 100", busy_cycles); else n_pass++;
        n_total++; if (capture[15:0] !== 16'd10)  $display("[TB] FAIL rise_cap0: got %0d want 10", capture[15:0]);  else n_pass++;
        n_total++; if (capture[31:16] !== 16'd0)  $display("[TB] FAIL rise_cap1: got %0d want 0", capture[31:16]);  else n_pass++;
        n_total++; if (capture[47:32] !== 16'd3)  $display("[TB] FAIL rise_cap2: got %0d want 3", capture[47:32]);  else n_pass++;
        n_total++; if (capture[63:48] !== 16'd0)  $display("[TB] FAIL rise_cap3: got %0d want 0", capture[63:48]);  else n_pass++;
    endtask

    task automatic test_edge_modes();
        logic [1:0] sels[4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [3:0] ens[4]  = '{4'hf, 4'hf, 4'hf, 4'b1101};
        int want[4]         = '{10, 5, 0, 0};
        int st[5];
        int w[5];
        for (int m = 0; m < 4; m++) begin
            for (int k = 0; k < 5; k++) begin
                st[k] = 5 + 10*k + $urandom_range(0, 3);
                w[k]  = $urandom_range(1, 3);
            end
            idle_inputs();
            edge_sel  = sels[m];
            ch_enable = ens[m];
            gate_len  = 16'd60;
            for (int j = 0; j <= 61; j++) begin
                in_pulse = '0;
                for (int k = 0; k < 5; k++) if (j >= st[k] && j < st[k] + w[k]) in_pulse[1] = 1'b1;
                start = (j == 0);
                tick();
            end
            n_total++;
            if (capture[31:16] !== 16'(want[m]))
                $display("[TB] FAIL edge_mode%0d_cap1: got %0d want %0d", m, capture[31:16], want[m]);
            else n_pass++;
            n_total++;
            if (capture !== exp_capture(0))
                $display("[TB] FAIL edge_mode%0d_model: got %0h want %0h", m, capture, exp_capture(0));
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        idle_inputs();
        gate_len = 16'd60;
        for (int j = 0; j <= 61; j++) begin
            in_pulse = '0;
            if (j >= 2 && j <= 34 && (j % 2) == 0) in_pulse[3] = 1'b1;
            start = (j == 0);
            tick();
        end
        n_total++; if (capture_w[15:12] !== 4'd1)  $display("[TB] FAIL ovf_wrap_cap: got %0d want 1", capture_w[15:12]);  else n_pass++;
        n_total++; if (overflow_w[3] !== 1'b1)     $display("[TB] FAIL ovf_wrap_flag: got %0h want 1", overflow_w[3]);    else n_pass++;
        n_total++; if (capture_s[15:12] !== 4'd15) $display("[TB] FAIL ovf_sat_cap: got %0d want 15", capture_s[15:12]);  else n_pass++;
        n_total++; if (overflow_s[3] !== 1'b1)     $display("[TB] FAIL ovf_sat_flag: got %0h want 1", overflow_s[3]);     else n_pass++;
        n_total++; if (capture[63:48] !== 16'd17)  $display("[TB] FAIL ovf_wide_cap: got %0d want 17", capture[63:48]);   else n_pass++;
        n_total++; if (overflow !== exp_ov(0))     $display("[TB] FAIL ovf_wide_flag: got %0h want %0h", overflow, exp_ov(0)); else n_pass++;
        gate_len = 16'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n_total++; if (overflow_w !== 4'd0) $display("[TB] FAIL ovf_start_clr_w: got %0h want 0", overflow_w); else n_pass++;
        n_total++; if (overflow_s !== 4'd0) $display("[TB] FAIL ovf_start_clr_s: got %0h want 0", overflow_s); else n_pass++;
        repeat (7) tick();
    endtask

    task automatic test_abort_clear();
        int n0;
        int na;
        bit done_seen = 1'b0;
        int done_at = -1;
        n0 = $urandom_range(1, 5);
        idle_inputs();
        gate_len = 16'd20;
        for (int j = 0; j <= 21; j++) begin
            in_pulse[0] = (j >= 2 && j < 2 + 2*n0 && (j % 2) == 0);
            start = (j == 0);
            tick();
        end
        n_total++; if (capture[15:0] !== 16'(n0)) $display("[TB] FAIL pre_abort_cap: got %0d want %0d", capture[15:0], n0); else n_pass++;

        na = $urandom_range(3, 10);
        gate_len = 16'd100;
        for (int j = 0; j <= 60; j++) begin
            in_pulse = '0;
            for (int k = 0; k < na; k++) if (j == 3 + 4*k || j == 4 + 4*k) in_pulse[1] = 1'b1;
            start = (j == 0);
            abort = (j == 50);
            tick();
            if (done === 1'b1) done_seen = 1'b1;
        end
        abort = 1'b0;
        n_total++; if (done_seen)                  $display("[TB] FAIL abort_done: got 1 want 0");                               else n_pass++;
        n_total++; if (busy !== 1'b0)              $display("[TB] FAIL abort_busy: got %0h want 0", busy);                       else n_pass++;
        n_total++; if (capture[15:0] !== 16'(n0))  $display("[TB] FAIL abort_cap_kept: got %0d want %0d", capture[15:0], n0);    else n_pass++;
        n_total++; if (count[31:16] !== 16'(na))   $display("[TB] FAIL abort_partial: got %0d want %0d", count[31:16], na);      else n_pass++;
        n_total++; if (count !== exp_count(0))     $display("[TB] FAIL abort_model: got %0h want %0h", count, exp_count(0));     else n_pass++;

        for (int j = 0; j <= 101; j++) begin
            in_pulse = '0;
            for (int k = 0; k < 8; k++) if (j == 10 + 6*k || j == 11 + 6*k) in_pulse[0] = 1'b1;
            start = (j == 0);
            clear = (j == 40 + LAT);
            tick();
            if (j == 40 + LAT) begin
                n_total++;
                if (count[15:0] !== 16'd0) $display("[TB] FAIL clear_edge: got %0d want 0", count[15:0]);
                else n_pass++;
            end
            if (done === 1'b1 && done_at < 0) done_at = j + 1;
        end
        clear = 1'b0;
        n_total++; if (done_at != 101)           $display("[TB] FAIL clear_done_cycle: got %0d want 101", done_at);  else n_pass++;
        n_total++; if (capture[15:0] !== 16'd2)  $display("[TB] FAIL clear_cap: got %0d want 2", capture[15:0]);   else n_pass++;
    endtask

    task automatic test_boundaries();
        int done_at = -1;
        idle_inputs();
        gate_len = 16'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n_total++; if (busy !== 1'b0) $display("[TB] FAIL gate0_busy: got %0h want 0", busy); else n_pass++;
        repeat (3) tick();
        n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL gate0_idle: got busy=%0h done=%0h want 0", busy, done); else n_pass++;

        gate_len = 16'd1;
        for (int j = -2; j <= 3; j++) begin
            in_pulse[0] = (j >= 1 - LAT);
            start = (j == 0);
            tick();
            if (done === 1'b1 && done_at < 0) done_at = j + 1;
        end
        in_pulse = '0;
        tick();
        n_total++; if (done_at != 2)             $display("[TB] FAIL gate1_done_cycle: got %0d want 2", done_at); else n_pass++;
        n_total++; if (capture[15:0] !== 16'd1)  $display("[TB] FAIL gate1_cap: got %0d want 1", capture[15:0]); else n_pass++;

        done_at = -1;
        gate_len = 16'd10;
        for (int j = 0; j <= 12; j++) begin
            in_pulse[0] = (j >= 2);
            start = (j == 0 || j == 4);
            if (j == 4) gate_len = 16'd50;
            tick();
            if (done === 1'b1 && done_at < 0) done_at = j + 1;
        end
        n_total++; if (done_at != 11)          $display("[TB] FAIL restart_done_cycle: got %0d want 11", done_at); else n_pass++;
        n_total++; if (count[15:0] !== 16'd1)  $display("[TB] FAIL restart_count: got %0d want 1", count[15:0]);   else n_pass++;
        in_pulse = '0;
        tick();
    endtask

    task automatic test_sync_latency();
        idle_inputs();
        gate_len = 16'd20;
        for (int j = 0; j <= 21; j++) begin
            in_pulse[0] = (j >= 5);
            start = (j == 0);
            tick();
            if (j >= 3 && j <= 5 + LAT + 1) begin
                n_total++;
                if (count[15:0] !== ((j >= 5 + LAT) ? 16'd1 : 16'd0))
                    $display("[TB] FAIL sync_latency j=%0d: got %0d want %0d", j, count[15:0], (j >= 5 + LAT) ? 1 : 0);
                else n_pass++;
            end
        end
        in_pulse = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        gate_len = 16'd100;
        for (int j = 0; j < 30; j++) begin
            in_pulse[2] = (j % 4 == 1);
            start = (j == 0);
            tick();
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_total++; if (busy !== 1'b0)     $display("[TB] FAIL rstmid_busy: got %0h want 0", busy);         else n_pass++;
        n_total++; if (count !== 64'd0)   $display("[TB] FAIL rstmid_count: got %0h want 0", count);       else n_pass++;
        n_total++; if (capture !== 64'd0) $display("[TB] FAIL rstmid_capture: got %0h want 0", capture);   else n_pass++;
        n_total++; if (overflow !== 4'd0 || done !== 1'b0)
            $display("[TB] FAIL rstmid_flags: got ovf=%0h done=%0h want 0", overflow, done); else n_pass++;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        idle_inputs();
        for (int j = 0; j < 400; j++) begin
            in_pulse  = 4'($urandom);
            ch_enable = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
            if ($urandom_range(0, 30) == 0) edge_sel = 2'($urandom);
            start    = ($urandom_range(0, 12) == 0);
            gate_len = 16'($urandom_range(0, 25));
            abort    = ($urandom_range(0, 40) == 0);
            clear    = ($urandom_range(0, 50) == 0);
            tick();
            n_total++;
            if (busy !== (m_left > 0) || done !== m_done)
                $display("[TB] FAIL rand_ctrl j=%0d: got busy=%0h done=%0h want busy=%0h done=%0h", j, busy, done, m_left > 0, m_done);
            else n_pass++;
            n_total++;
            if (count !== exp_count(0) || capture !== exp_capture(0) || overflow !== exp_ov(0))
                $display("[TB] FAIL rand_wide j=%0d: got %0h/%0h/%0h want %0h/%0h/%0h", j, count, capture, overflow,
                         exp_count(0), exp_capture(0), exp_ov(0));
            else n_pass++;
            n_total++;
            if (count_w !== 16'(exp_count(1)) || capture_w !== 16'(exp_capture(1)) || overflow_w !== exp_ov(1))
                $display("[TB] FAIL rand_wrap4 j=%0d: got %0h/%0h/%0h want %0h/%0h/%0h", j, count_w, capture_w, overflow_w,
                         16'(exp_count(1)), 16'(exp_capture(1)), exp_ov(1));
            else n_pass++;
            n_total++;
            if (count_s !== 16'(exp_count(2)) || capture_s !== 16'(exp_capture(2)) || overflow_s !== exp_ov(2))
                $display("[TB] FAIL rand_sat4 j=%0d: got %0h/%0h/%0h want %0h/%0h/%0h", j, count_s, capture_s, overflow_s,
                         16'(exp_count(2)), 16'(exp_capture(2)), exp_ov(2));
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_rising();
        test_edge_modes();
        test_overflow();
        test_abort_clear();
        test_boundaries();
        test_sync_latency();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/pulse_counter_mc.md
Name: pulse_counter_mc

Overview:
Multi-channel gated pulse counter: the parametrised successor of the single-channel pulse counter. It counts selectable edges on CHANNELS independent inputs during a programmable measurement window of gate_len clocks. At window end it snapshots every channel into capture registers and pulses done. It sits between the pulse front-ends and the register/readout logic of the controller.

Parameters:
CHANNELS, 4, number of independent input channels (1..16)
WIDTH, 16, counter width per channel (4..32)
GATE_W, 16, width of gate_len / window timer
SATURATE, 0, 1 = counters stick at 2^WIDTH-1; 0 = counters wrap to 0
SYNC_STAGES, 2, synchroniser depth per input (used only with PULSE_CNT_SYNC_EN; >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
in_pulse  in  CHANNELS  pulse inputs, one bit per channel
ch_enable  in  CHANNELS  per-channel count enable, sampled every cycle
edge_sel  in  2  00 rising, 01 falling, 10 both, 11 none
start  in  1  single-cycle strobe, opens a window
abort  in  1  terminates window with no capture
clear  in  1  synchronous zero of live counters and overflow
gate_len  in  GATE_W  window length in clocks, sampled on accepted start
busy  out  1  high in COUNT state
done  out  1  one-cycle pulse in DONE state
count  out  CHANNELS*WIDTH  live counters, channel i at [i*WIDTH +: WIDTH]
capture  out  CHANNELS*WIDTH  window snapshot, same packing
overflow  out  CHANNELS  sticky per-channel overflow flag

Behaviour:
- Reset (async, rst=1): state IDLE; count, capture, overflow, timer, edge-detect history all 0; busy=0; done=0.
- Edge detect per channel: prev <= sampled input every cycle, in every state. Edge is selected by edge_sel: rising = s&~prev; falling = ~s&prev; both = s^prev. Because prev resets to 0, an input already high when reset is released registers as a rising edge.
- Increment for channel i: state==COUNT && ch_enable[i] && edge. The count output shows the new value on the clock after the sampled edge.
- Width rule: at 2^WIDTH-1, an increment sets overflow[i]. With SATURATE=1 the value holds; with SATURATE=0 it wraps to 0. overflow stays set until clear, an accepted start, or reset.
- FSM states: IDLE, COUNT, DONE.
  - IDLE: start && gate_len!=0 -> COUNT. On that edge: timer<=gate_len; all count and overflow cleared. start with gate_len==0 is ignored.
  - COUNT: busy=1. The timer decrements every cycle. When timer==1 -> DONE. COUNT therefore lasts exactly gate_len cycles, and edges in the last COUNT cycle are included. start is ignored. abort -> IDLE with capture unchanged and no done; live counts are retained.
  - DONE: lasts one cycle; done=1; capture<=count (the final values); -> IDLE. abort and start are ignored.
- clear: valid in any state. It zeroes count and overflow and takes priority over a same-cycle increment. It does not stop the timer or change state. capture is unaffected.
- Simultaneous events: abort has priority over timer expiry in COUNT. An accepted start plus an edge in the same cycle: the edge is not counted (the state is still IDLE).
- Outside COUNT the counters hold their value.

Optional Feature:
Macro: PULSE_CNT_SYNC_EN.
- Defined: each in_pulse bit passes through a SYNC_STAGES flop synchroniser (reset 0) before edge detect. Pin-to-count latency grows by SYNC_STAGES cycles, and inputs may be asynchronous.
- Undefined: in_pulse feeds edge detect directly and must be synchronous to clk. SYNC_STAGES is unused.

Test Plan:
- Rising count: macro off, CHANNELS=4, WIDTH=16, edge_sel=00, ch_enable=1111, gate_len=100; start, then 10 pulses of 2 cycles on ch0 and 3 on ch2 -> done exactly 101 cycles after start; capture ch0=10, ch1=0, ch2=3, ch3=0; busy high for 100 cycles.
- Edge modes: 5 full pulses on ch1 with edge_sel=10 -> capture 10; edge_sel=01 -> 5; edge_sel=11 -> 0. With ch_enable[1]=0 -> 0.
- Overflow: WIDTH=4, 17 rising edges. SATURATE=0 -> capture=1, overflow=1. SATURATE=1 -> capture=15, overflow=1. A following start -> overflow=0.
- Abort and clear: abort at cycle 50 of a 100-cycle window -> no done; capture keeps its previous value; count holds partial value. clear mid-window at the same cycle as an edge -> count=0 and the timer still expires on schedule.
- Boundaries: start with gate_len=0 -> stays IDLE, busy=0. gate_len=1 with an edge in the single COUNT cycle -> capture=1 and done 2 cycles after start. start during COUNT -> ignored.
- Reset and sync: rst asserted mid-window -> all outputs 0 immediately. With PULSE_CNT_SYNC_EN and SYNC_STAGES=2, count updates 2 cycles later than with the macro off for the same stimulus.
